// File: rtl/imem_loader.sv
// imem_loader: reassembles a length-prefixed, XOR-checked byte stream into instruction memory words
module imem_loader #(
    parameter int ADDR_W    = 13,
    parameter int MAX_WORDS = 2048
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
    state_t state, state_nxt;
    logic [15:0] len, word_idx, len_full;
    logic [1:0]  byte_cnt;
    logic [23:0] word_lo;
    logic [7:0]  chk;
    logic        acc, go, last_word;
    assign acc       = i_rx_valid & o_rx_ready;
    assign go        = i_start & (state == IDLE || state == DONE || state == ERR);
    assign len_full  = {i_rx_data, len[7:0]};
    assign last_word = word_idx == len - 16'd1;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: state_nxt = go ? LEN0 : state;
            LEN0: state_nxt = acc ? LEN1 : LEN0;
            LEN1: state_nxt = !acc ? LEN1 : len_full == 16'd0 ? CHK : len_full > MAX_N ? ERR : DATA;
            DATA: state_nxt = (acc && byte_cnt == 2'd3 && last_word) ? CHK : DATA;
            CHK:  state_nxt = !acc ? CHK : i_rx_data == chk ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else state <= state_nxt;
    end
    // Status outputs are registered from the next state so they track it without lag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rx_ready <= 1'b0;
            o_we       <= 1'b0;
            o_waddr    <= '0;
            o_wdata    <= '0;
            o_cpu_hold <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_lo    <= '0;
            chk        <= '0;
        end else begin
            o_we       <= 1'b0;
            o_rx_ready <= state_nxt == LEN0 || state_nxt == LEN1 || state_nxt == DATA || state_nxt == CHK;
            o_done     <= state_nxt == DONE;
            o_err      <= state_nxt == ERR;
            o_cpu_hold <= state_nxt != DONE;
            if (go) begin
                word_idx <= '0;
                byte_cnt <= '0;
                chk      <= '0;
            end
            if (acc && state == LEN0) len[7:0] <= i_rx_data;
            if (acc && state == LEN1) len[15:8] <= i_rx_data;
            if (acc && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                chk      <= chk ^ i_rx_data;
                word_lo  <= {i_rx_data, word_lo[23:8]};
                if (byte_cnt == 2'd3) begin
                    o_we     <= 1'b1;
                    o_waddr  <= {word_idx[ADDR_W-3:0], 2'b00};
                    o_wdata  <= {i_rx_data, word_lo};
                    word_idx <= word_idx + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for the instruction memory loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, we, cpu_hold, done, err;
    logic [12:0] waddr;
    logic [31:0] wdata;
    int checks = 0, failures = 0, writes = 0;
    logic [44:0] exp_q[$];
    logic [31:0] img[$];

    imem_loader dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_rx_valid(rx_valid),
        .i_rx_data(rx_data), .o_rx_ready(rx_ready), .o_we(we), .o_waddr(waddr),
        .o_wdata(wdata), .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) check("we_unexpected", 32'(we), 32'd0);
            else begin
                logic [44:0] e;
                e = exp_q.pop_front();
                check("waddr", 32'(waddr), 32'(e[44:32]));
                check("wdata", wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int maxgap, input bit poke);
        int n, gap;
        gap = $urandom_range(0, maxgap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start = poke ? 1'($urandom % 2) : 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        rx_valid = 1'b1;
        rx_data = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("rx_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input int maxgap, input bit poke, input bit force_chk, input logic [7:0] chk_val);
        logic [15:0] n;
        logic [7:0]  x;
        n = 16'(img.size());
        x = 8'h00;
        send(n[7:0], maxgap, 1'b0);
        send(n[15:8], maxgap, 1'b0);
        for (int w = 0; w < img.size(); w++) begin
            exp_q.push_back({13'(w * 4), img[w]});
            for (int k = 0; k < 4; k++) begin
                x = x ^ img[w][8*k +: 8];
                send(img[w][8*k +: 8], maxgap, poke);
            end
        end
        send(force_chk ? chk_val : x, maxgap, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(rx_ready), 32'd0);

        img = '{32'h00000013, 32'h000010B7};
        start_pulse();
        check("len0_ready", 32'(rx_ready), 32'd1);
        send_frame(0, 1'b0, 1'b1, 8'hB4);
        check("good_done", 32'(done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_err", 32'(err), 32'd0);
        check("good_ready", 32'(rx_ready), 32'd0);
        check("good_writes", 32'(writes), 32'd2);

        start_pulse();
        check("restart_done", 32'(done), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        send_frame(0, 1'b0, 1'b1, 8'h00);
        check("bad_err", 32'(err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_writes", 32'(writes), 32'd4);
        start_pulse();
        check("err_clear", 32'(err), 32'd0);
        check("err_ready", 32'(rx_ready), 32'd1);

        send(8'h01, 0, 1'b0);
        send(8'h08, 0, 1'b0);
        @(negedge clk);
        check("len_err", 32'(err), 32'd1);
        check("len_ready", 32'(rx_ready), 32'd0);
        check("len_writes", 32'(writes), 32'd4);

        img = {};
        start_pulse();
        send_frame(0, 1'b0, 1'b0, 8'h00);
        check("empty_done", 32'(done), 32'd1);
        check("empty_writes", 32'(writes), 32'd4);

        img = '{$urandom, $urandom, $urandom};
        w0 = writes;
        start_pulse();
        send_frame(3, 1'b1, 1'b0, 8'h00);
        check("gap_done", 32'(done), 32'd1);
        check("gap_writes", 32'(writes - w0), 32'd3);
        check("gap_q_empty", 32'(exp_q.size()), 32'd0);

        w0 = writes;
        start_pulse();
        send(8'h02, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        exp_q.push_back({13'h000, 32'hA1B2C3D4});
        send(8'hD4, 0, 1'b0); send(8'hC3, 0, 1'b0); send(8'hB2, 0, 1'b0); send(8'hA1, 0, 1'b0);
        send(8'h55, 0, 1'b0); send(8'h66, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hold", 32'(cpu_hold), 32'd1);
        check("abort_ready", 32'(rx_ready), 32'd0);
        check("abort_we", 32'(we), 32'd0);
        repeat (5) @(negedge clk);
        check("abort_writes", 32'(writes - w0), 32'd1);
        img = '{$urandom};
        start_pulse();
        send_frame(0, 1'b0, 1'b0, 8'h00);
        check("reload_done", 32'(done), 32'd1);
        check("reload_writes", 32'(writes - w0), 32'd2);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
